// File: rtl/complex_addsub.sv
// rtl/complex_addsub.sv - registered complex adder/subtractor with per-component overflow
//
// Optional build macro: COMPLEX_ADDSUB_SATURATE_EN (clamp overflowing components).
// Ports:
//   clk       - clock, all state on rising edge
//   rst       - synchronous active-high reset
//   in_valid  - a, b, op valid this cycle
//   a, b      - packed signed complex operands {re[2W-1:W], im[W-1:0]}
//   op        - 0 = a+b, 1 = a-b (applies to both components)
//   s         - registered result {re, im}
//   out_valid - s and flags valid this cycle
//   ovf_re    - real component signed overflow
//   ovf_im    - imaginary component signed overflow
module complex_addsub #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  input  logic           op,
  output logic [2*W-1:0] s,
  output logic           out_valid,
  output logic           ovf_re,
  output logic           ovf_im
);

  logic [2*W-1:0] s_q, s_d;
  logic           valid_q;
  logic           ovf_re_q, ovf_re_d;
  logic           ovf_im_q, ovf_im_d;

  logic [W:0] re_full, im_full;
  logic [W-1:0] re_res, im_res;

  // W+1-bit add/subtract; subtraction is a + ~b + 1 so the most negative
  // operand is handled without a separate negation step.
  function automatic logic [W:0] addsub(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic sub);
    logic [W:0] xe, ye;
    xe = {x[W-1], x};
    ye = {y[W-1], y};
    if (sub) begin
      ye = ~ye;
    end
    return xe + ye + {{W{1'b0}}, sub};
  endfunction

  // Bit W holds the true sign of the full result, so it picks the clamp
  // direction when the component overflows.
  function automatic logic [W-1:0] fit(input logic [W:0] full);
    logic [W-1:0] r;
    r = full[W-1:0];
`ifdef COMPLEX_ADDSUB_SATURATE_EN
    if (full[W] != full[W-1]) begin
      r = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
    return r;
  endfunction

  always_comb begin
    re_full  = addsub(a[2*W-1:W], b[2*W-1:W], op);
    im_full  = addsub(a[W-1:0], b[W-1:0], op);
    re_res   = fit(re_full);
    im_res   = fit(im_full);
    s_d      = {re_res, im_res};
    ovf_re_d = re_full[W] ^ re_full[W-1];
    ovf_im_d = im_full[W] ^ im_full[W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q      <= '0;
      valid_q  <= 1'b0;
      ovf_re_q <= 1'b0;
      ovf_im_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      // Result and flags only load on valid input and otherwise hold.
      if (in_valid) begin
        s_q      <= s_d;
        ovf_re_q <= ovf_re_d;
        ovf_im_q <= ovf_im_d;
      end
    end
  end

  assign s         = s_q;
  assign out_valid = valid_q;
  assign ovf_re    = ovf_re_q;
  assign ovf_im    = ovf_im_q;

endmodule

// File: tb/tb_complex_addsub.sv
// tb/tb_complex_addsub.sv - self-checking bench for complex_addsub (W=8)
module tb_complex_addsub;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [2*W-1:0] a, b;
  logic           op;
  logic [2*W-1:0] s;
  logic           out_valid, ovf_re, ovf_im;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  complex_addsub #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .op(op),
    .s(s), .out_valid(out_valid), .ovf_re(ovf_re), .ovf_im(ovf_im)
  );

  typedef struct {
    int ar, ai, br, bi;
    logic op;
    int er, ei;
    logic eovr, eovi;
  } vec_t;

  vec_t vecs[6];

  // Expected state kept by the bench
  logic [2*W-1:0] exp_s;
  logic           exp_v, exp_or, exp_oi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_all(input string name);
    chk({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_v});
    chk({name, ".s"}, {16'd0, s}, {16'd0, exp_s});
    chk({name, ".ovf_re"}, {31'd0, ovf_re}, {31'd0, exp_or});
    chk({name, ".ovf_im"}, {31'd0, ovf_im}, {31'd0, exp_oi});
  endtask

  // Plain integer arithmetic on the true values, then wrap or clamp.
  function automatic logic [W:0] model_comp(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic sub);
    int xi, yi, t, r;
    logic ov;
    xi = int'($signed(x));
    yi = int'($signed(y));
    t  = sub ? xi - yi : xi + yi;
    ov = (t > 127) || (t < -128);
    r  = t;
`ifdef COMPLEX_ADDSUB_SATURATE_EN
    if (t > 127) r = 127;
    if (t < -128) r = -128;
`endif
    return {ov, 8'(r)};
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [2*W-1:0] ma,
                            input logic [2*W-1:0] mb, input logic mop);
    logic [W:0] cr, ci;
    if (r) begin
      exp_s = '0; exp_v = 1'b0; exp_or = 1'b0; exp_oi = 1'b0;
    end else begin
      exp_v = v;
      if (v) begin
        cr = model_comp(ma[15:8], mb[15:8], mop);
        ci = model_comp(ma[7:0], mb[7:0], mop);
        exp_s  = {cr[7:0], ci[7:0]};
        exp_or = cr[8];
        exp_oi = ci[8];
      end
    end
  endtask

  task automatic drive_vec(input vec_t v);
    a  = {8'(v.ar), 8'(v.ai)};
    b  = {8'(v.br), 8'(v.bi)};
    op = v.op;
    in_valid = 1'b1;
  endtask

  initial begin
    vecs[0] = '{-10, 15, 13, -18, 1'b1, -23, 33, 1'b0, 1'b0};
    vecs[1] = '{16, 3, 12, -64, 1'b0, 28, -61, 1'b0, 1'b0};
    vecs[2] = '{2, 18, -50, 32, 1'b0, -48, 50, 1'b0, 1'b0};
    vecs[3] = '{54, 31, -12, -37, 1'b1, 66, 68, 1'b0, 1'b0};
`ifdef COMPLEX_ADDSUB_SATURATE_EN
    vecs[4] = '{100, -100, 100, -100, 1'b0, 127, -128, 1'b1, 1'b1};
    vecs[5] = '{-128, 0, 1, 0, 1'b1, -128, 0, 1'b1, 1'b0};
`else
    vecs[4] = '{100, -100, 100, -100, 1'b0, -56, 56, 1'b1, 1'b1};
    vecs[5] = '{-128, 0, 1, 0, 1'b1, 127, 0, 1'b1, 1'b0};
`endif

    // Reset held two cycles with valid operands present
    rst = 1'b1;
    drive_vec(vecs[4]);
    exp_s = '0; exp_v = 1'b0; exp_or = 1'b0; exp_oi = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk_all("reset");
    end
    rst = 1'b0;

    // Directed table, back-to-back, each result one cycle later
    for (int i = 0; i < 6; i++) begin
      drive_vec(vecs[i]);
      @(posedge clk); #1;
      exp_v  = 1'b1;
      exp_s  = {8'(vecs[i].er), 8'(vecs[i].ei)};
      exp_or = vecs[i].eovr;
      exp_oi = vecs[i].eovi;
      chk_all($sformatf("vec%0d", i));
    end

    // a - a gives zero, no overflow
    a = 16'h8080; b = 16'h8080; op = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    exp_v = 1'b1; exp_s = '0; exp_or = 1'b0; exp_oi = 1'b0;
    chk_all("a_minus_a");

    // Valid gaps: out_valid follows in_valid one cycle later, s holds
    for (int i = 0; i < 8; i++) begin
      in_valid = ~i[0];
      a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
      model_step(1'b0, in_valid, a, b, op);
      @(posedge clk); #1;
      chk_all($sformatf("gap%0d", i));
    end

    // Mid-stream reset discards the in-flight result
    a = 16'h1234; b = 16'h0101; op = 1'b0; in_valid = 1'b1; rst = 1'b1;
    model_step(1'b1, 1'b1, a, b, op);
    @(posedge clk); #1;
    chk_all("midreset");
    rst = 1'b0;
    model_step(1'b0, 1'b1, a, b, op);
    @(posedge clk); #1;
    chk_all("after_reset");

    // Randomized run against the model
    for (int i = 0; i < 10000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      in_valid = 1'($urandom);
      a  = 16'($urandom);
      b  = 16'($urandom);
      op = 1'($urandom);
      if (i % 97 == 0) begin
        a = {8'h80, 8'h7f};
      end
      model_step(rst, in_valid, a, b, op);
      @(posedge clk); #1;
      chk_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
